// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC product-parity receive path: codeword field
// offsets, sizes, status encodings and the decoder state enum.
`timescale 1ns/1ps
package lpc_pkg;

    localparam int LPC_WORD_W   = 80;
    localparam int LPC_BYTES    = 8;
    localparam int LPC_BEATS    = 4;
    localparam int LPC_DATA_W   = 64;
    localparam int LPC_SAMPLE_W = 16;

    // Field offsets inside the 80-bit codeword.
    localparam int LPC_BYTE0_MSB = 79;  // byte i lives at [79-8i -: 8]
    localparam int LPC_PV_MSB    = 15;  // row (per-byte) parity, [15:8]
    localparam int LPC_PH_MSB    = 7;   // column (per-bit) parity, [7:0]

    typedef logic [1:0] lpc_err_t;
    localparam lpc_err_t ERR_NONE   = 2'b00;
    localparam lpc_err_t ERR_DATA   = 2'b01;
    localparam lpc_err_t ERR_PAR    = 2'b10;
    localparam lpc_err_t ERR_UNCORR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EMIT   = 2'd2
    } lpc_state_e;

    // True when exactly one bit of a syndrome byte is set.
    function automatic logic one_hot8(input logic [7:0] x);
        return (x != 8'h00) && ((x & (x - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/lpc_decoder_if.sv
// Codeword input stream and sample output stream of the LPC decoder.
// Handshake: a transfer happens on a rising ACLK edge where valid and ready
// are both high; once valid is raised, the source holds valid and its payload
// unchanged until that transfer, and ready may be asserted independently.
`timescale 1ns/1ps
interface lpc_decoder_if;

    logic        IN_VALID;
    logic [79:0] IN_CODED;
    logic [3:0]  IN_LAST;
    logic        IN_TUSER;
    logic        READY;

    logic        OUT_VALID;
    logic [15:0] OUT_SAMPLE;
    logic        OUT_SAMPLE_LAST;
    logic        OUT_T_LAST;
    logic [1:0]  OUT_ERR;
    logic        T_READY;

    // Drives codewords in and consumes samples (link model + sample sink).
    modport master (
        output IN_VALID, IN_CODED, IN_LAST, IN_TUSER, T_READY,
        input  READY, OUT_VALID, OUT_SAMPLE, OUT_SAMPLE_LAST, OUT_T_LAST, OUT_ERR
    );

    // The decoder side.
    modport slave (
        input  IN_VALID, IN_CODED, IN_LAST, IN_TUSER, T_READY,
        output READY, OUT_VALID, OUT_SAMPLE, OUT_SAMPLE_LAST, OUT_T_LAST, OUT_ERR
    );

endinterface

// File: rtl/lpc_syndrome.sv
// Combinational product-parity check: computes row and column syndromes,
// classifies the codeword and flips the single faulty data bit if there is one.
`timescale 1ns/1ps
module lpc_syndrome
    import lpc_pkg::*;
(
    input  logic [LPC_WORD_W-1:0] coded,
    output logic [LPC_DATA_W-1:0] payload,
    output lpc_err_t              status
);

    logic [7:0]            pv;
    logic [7:0]            ph;
    logic [7:0]            rs;
    logic [7:0]            cs;
    logic [LPC_DATA_W-1:0] flip;

    // Syndromes, classification and single-bit correction of the payload.
    always_comb begin
        pv   = coded[LPC_PV_MSB -: 8];
        ph   = coded[LPC_PH_MSB -: 8];
        rs   = '0;
        cs   = ph;
        flip = '0;
        for (int i = 0; i < LPC_BYTES; i++) begin
            rs[i] = (^coded[LPC_BYTE0_MSB - 8*i -: 8]) ^ pv[i];
            cs    = cs ^ coded[LPC_BYTE0_MSB - 8*i -: 8];
        end

        if ((rs == 8'h00) && (cs == 8'h00)) begin
            status = ERR_NONE;
        end else if (one_hot8(rs) && one_hot8(cs)) begin
            status = ERR_DATA;
        end else if ((one_hot8(rs) && (cs == 8'h00)) || ((rs == 8'h00) && one_hot8(cs))) begin
            status = ERR_PAR;
        end else begin
            status = ERR_UNCORR;
        end

        // Row r and column c cross at exactly one data bit when both are one-hot.
        if (status == ERR_DATA) begin
            for (int i = 0; i < LPC_BYTES; i++) begin
                for (int j = 0; j < 8; j++) begin
                    flip[LPC_DATA_W - 8 - 8*i + j] = rs[i] & cs[j];
                end
            end
        end

        payload = coded[LPC_WORD_W-1 -: LPC_DATA_W] ^ flip;
    end

endmodule

// File: rtl/lpc_decoder.sv
// LPC product-parity receiver: accepts one codeword, decodes it in a single
// DECODE cycle and emits the payload as four 16-bit samples.
// Optional build macro LPC_DEC_ERR_CNT_EN adds saturating error counters;
// without it CORR_CNT/UNCORR_CNT are tied to zero.
`timescale 1ns/1ps
module lpc_decoder
    import lpc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET_N,
    lpc_decoder_if.slave     bus,
    output logic [CNT_W-1:0] CORR_CNT,
    output logic [CNT_W-1:0] UNCORR_CNT,
    output lpc_state_e       dbg_state
);

    lpc_state_e            state_q;
    lpc_state_e            state_d;
    logic                  ready;
    logic                  out_valid;
    logic                  accept;
    logic                  beat_hs;

    logic [LPC_WORD_W-1:0] cw_q;
    logic [3:0]            last_q;
    logic [LPC_DATA_W-1:0] data_q;
    lpc_err_t              err_q;
    logic [1:0]            beat_q;

    logic [LPC_DATA_W-1:0] syn_payload;
    lpc_err_t              syn_status;

    lpc_syndrome u_syndrome (
        .coded   (cw_q),
        .payload (syn_payload),
        .status  (syn_status)
    );

    // A flush wins over any handshake happening in the same cycle.
    assign accept  = bus.IN_VALID && (state_q == ST_IDLE) && !bus.IN_TUSER;
    assign beat_hs = (state_q == ST_EMIT) && bus.T_READY && !bus.IN_TUSER;

    // State register.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.IN_VALID) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EMIT;
            ST_EMIT: begin
                out_valid = 1'b1;
                if (bus.T_READY && (beat_q == 2'd3)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.IN_TUSER) state_d = ST_IDLE;
    end

    // Codeword capture, decoded payload/status and beat index.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            cw_q   <= '0;
            last_q <= '0;
            data_q <= '0;
            err_q  <= ERR_NONE;
            beat_q <= '0;
        end else if (bus.IN_TUSER) begin
            cw_q   <= '0;
            last_q <= '0;
            data_q <= '0;
            err_q  <= ERR_NONE;
            beat_q <= '0;
        end else begin
            if (accept) begin
                cw_q   <= bus.IN_CODED;
                last_q <= bus.IN_LAST;
            end
            if (state_q == ST_DECODE) begin
                data_q <= syn_payload;
                err_q  <= syn_status;
                beat_q <= '0;
            end
            // Wraps back to 0 after the beat-3 transfer.
            if (beat_hs) beat_q <= beat_q + 2'd1;
        end
    end

    // Sample k is bytes 2k and 2k+1, most significant byte first.
    always_comb begin
        case (beat_q)
            2'd0:    bus.OUT_SAMPLE = data_q[63:48];
            2'd1:    bus.OUT_SAMPLE = data_q[47:32];
            2'd2:    bus.OUT_SAMPLE = data_q[31:16];
            default: bus.OUT_SAMPLE = data_q[15:0];
        endcase
    end

    assign bus.READY           = ready;
    assign bus.OUT_VALID       = out_valid;
    assign bus.OUT_SAMPLE_LAST = last_q[beat_q];
    assign bus.OUT_T_LAST      = (beat_q == 2'd3);
    assign bus.OUT_ERR         = err_q;
    assign dbg_state           = state_q;

`ifdef LPC_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] corr_q;
    logic [CNT_W-1:0] uncorr_q;

    // Saturating per-codeword error counters, updated in the DECODE cycle.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if ((state_q == ST_DECODE) && !bus.IN_TUSER) begin
            if ((syn_status == ERR_DATA) || (syn_status == ERR_PAR)) begin
                if (corr_q != '1) corr_q <= corr_q + 1'b1;
            end else if (syn_status == ERR_UNCORR) begin
                if (uncorr_q != '1) uncorr_q <= uncorr_q + 1'b1;
            end
        end
    end

    assign CORR_CNT   = corr_q;
    assign UNCORR_CNT = uncorr_q;
`else
    assign CORR_CNT   = '0;
    assign UNCORR_CNT = '0;
`endif

endmodule

// File: tb/tb_lpc_decoder.sv
// Bench for lpc_decoder: directed codewords from the test plan plus randomized
// traffic, all checked against a sample-level reference model.
`timescale 1ns/1ps
module tb_lpc_decoder;
    import lpc_pkg::*;

    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    logic ARESET_N = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc++;

    lpc_decoder_if bus();
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;
    lpc_state_e       dbg_state;

    lpc_decoder #(.CNT_W(CNT_W)) dut (
        .ACLK       (ACLK),
        .ARESET_N   (ARESET_N),
        .bus        (bus),
        .CORR_CNT   (corr_cnt),
        .UNCORR_CNT (uncorr_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [19:0] exp_q[$];   // {err, t_last, sample_last, sample}
    int model_corr = 0;
    int model_uncorr = 0;
    bit rand_tready = 1'b0;

`ifdef LPC_DEC_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the codeword as an 8x8 bit matrix plus its two parity vectors.
    function automatic void model_decode(input logic [79:0] cw, output logic [63:0] pay,
                                         output logic [1:0] err);
        logic [7:0] b [8];
        logic [7:0] pv, ph, rs, cs;
        int nr, nc, r, c;
        pv = cw[15:8];
        ph = cw[7:0];
        for (int i = 0; i < 8; i++) b[i] = cw[79 - 8*i -: 8];
        r = 0; c = 0;
        for (int i = 0; i < 8; i++) begin
            rs[i] = pv[i];
            for (int j = 0; j < 8; j++) rs[i] = rs[i] ^ b[i][j];
            if (rs[i]) r = i;
        end
        for (int j = 0; j < 8; j++) begin
            cs[j] = ph[j];
            for (int i = 0; i < 8; i++) cs[j] = cs[j] ^ b[i][j];
            if (cs[j]) c = j;
        end
        nr = $countones(rs);
        nc = $countones(cs);
        if (nr == 0 && nc == 0) err = 2'b00;
        else if (nr == 1 && nc == 1) begin
            err = 2'b01;
            b[r][c] = ~b[r][c];
        end else if (nr + nc == 1) err = 2'b10;
        else err = 2'b11;
        pay = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    function automatic logic [79:0] encode(input logic [63:0] data);
        logic [7:0] pv, ph, by;
        ph = 8'h00;
        for (int i = 0; i < 8; i++) begin
            by = data[63 - 8*i -: 8];
            pv[i] = ^by;
            ph = ph ^ by;
        end
        return {data, pv, ph};
    endfunction

    // ---------------- compare process ----------------
    bit          first_pending = 1'b0;
    int          acc_cyc = 0;
    bit          prev_stall = 1'b0;
    logic [19:0] prev_out = '0;

    always @(negedge ACLK) begin
        logic [63:0] pay;
        logic [1:0]  err;
        logic [19:0] e;
        logic [19:0] cur;
        if (!ARESET_N) begin
            exp_q.delete();
            model_corr = 0;
            model_uncorr = 0;
            first_pending = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cur = {bus.OUT_ERR, bus.OUT_T_LAST, bus.OUT_SAMPLE_LAST, bus.OUT_SAMPLE};
            check("ready_vs_valid", {78'd0, bus.READY, bus.OUT_VALID} & 80'h3, 80'h2 & {78'd0, 2'b00} | ((bus.READY && bus.OUT_VALID) ? 80'h0 : {78'd0, bus.READY, bus.OUT_VALID}));
            if (prev_stall) begin
                check("stall_valid_held", bus.OUT_VALID, 1'b1);
                check("stall_outputs_stable", cur, prev_out);
            end
            if (first_pending && bus.OUT_VALID) begin
                check("first_valid_latency", cyc - acc_cyc, 2);
                first_pending = 1'b0;
            end
            if (bus.IN_TUSER) begin
                exp_q.delete();
                first_pending = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (bus.OUT_VALID && bus.T_READY) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_beat", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_sample", bus.OUT_SAMPLE, e[15:0]);
                        check("beat_sample_last", bus.OUT_SAMPLE_LAST, e[16]);
                        check("beat_t_last", bus.OUT_T_LAST, e[17]);
                        check("beat_err", bus.OUT_ERR, e[19:18]);
                    end
                end
                if (bus.IN_VALID && bus.READY) begin
                    model_decode(bus.IN_CODED, pay, err);
                    for (int k = 0; k < 4; k++)
                        exp_q.push_back({err, (k == 3), bus.IN_LAST[k], pay[63 - 16*k -: 16]});
                    if (CNT_ON) begin
                        if ((err == 2'b01 || err == 2'b10) && model_corr < 65535) model_corr++;
                        if (err == 2'b11 && model_uncorr < 65535) model_uncorr++;
                    end
                    acc_cyc = cyc;
                    first_pending = 1'b1;
                end
                prev_stall = bus.OUT_VALID && !bus.T_READY;
            end
            prev_out = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge ACLK);
        #1;
        if (rand_tready) bus.T_READY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_cw(input logic [79:0] cw, input logic [3:0] last);
        int n = 0;
        bus.IN_VALID = 1'b1;
        bus.IN_CODED = cw;
        bus.IN_LAST  = last;
        while (!bus.READY && n < 200) begin
            step();
            n++;
        end
        check("accept_timeout", (n >= 200), 1'b0);
        step();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.READY) && n < 300) begin
            step();
            n++;
        end
        check("drain_timeout", (n >= 300), 1'b0);
    endtask

    // Waits until beat k of the current codeword is presented.
    task automatic wait_beat(input int k);
        int n = 0;
        while (!(bus.OUT_VALID && exp_q.size() == 4 - k) && n < 50) begin
            step();
            n++;
        end
        check("wait_beat_timeout", (n >= 50), 1'b0);
    endtask

    // ---------------- main sequence ----------------
    localparam logic [79:0] CW_CLEAN  = {64'h1234_5678_9ABC_DEF0, 8'h22, 8'h00};
    localparam logic [79:0] CW_DATA   = {64'h1234_5658_9ABC_DEF0, 8'h22, 8'h00};
    localparam logic [79:0] CW_PV     = {64'h1234_5678_9ABC_DEF0, 8'h23, 8'h00};
    localparam logic [79:0] CW_PH     = {64'h1234_5678_9ABC_DEF0, 8'h22, 8'h80};
    localparam logic [79:0] CW_DOUBLE = {64'h1334_5678_9A3C_DEF0, 8'h22, 8'h00};

    initial begin
        logic [63:0] pay;
        logic [1:0]  err;
        logic [79:0] cw;
        int          idx, idx2, kind;

        bus.IN_VALID = 1'b0;
        bus.IN_CODED = '0;
        bus.IN_LAST  = '0;
        bus.IN_TUSER = 1'b0;
        bus.T_READY  = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESET_N = 1'b1;

        // Reset values.
        check("rst_ready", bus.READY, 1'b1);
        check("rst_out_valid", bus.OUT_VALID, 1'b0);
        check("rst_sample", bus.OUT_SAMPLE, 16'h0);
        check("rst_sample_last", bus.OUT_SAMPLE_LAST, 1'b0);
        check("rst_t_last", bus.OUT_T_LAST, 1'b0);
        check("rst_err", bus.OUT_ERR, 2'b00);
        check("rst_corr_cnt", corr_cnt, 0);
        check("rst_uncorr_cnt", uncorr_cnt, 0);

        // Hand-computed pins on the model itself.
        model_decode(CW_CLEAN, pay, err);
        check("model_clean_pay", pay, 64'h1234_5678_9ABC_DEF0);
        check("model_clean_err", err, 2'b00);
        check("model_encode_clean", encode(64'h1234_5678_9ABC_DEF0), CW_CLEAN);
        model_decode(CW_DATA, pay, err);
        check("model_data_pay", pay, 64'h1234_5678_9ABC_DEF0);
        check("model_data_err", err, 2'b01);
        model_decode(CW_PV, pay, err);
        check("model_pv_err", err, 2'b10);
        model_decode(CW_PH, pay, err);
        check("model_ph_err", err, 2'b10);
        model_decode(CW_DOUBLE, pay, err);
        check("model_double_pay", pay, 64'h1334_5678_9A3C_DEF0);
        check("model_double_err", err, 2'b11);

        // Directed codewords from the plan.
        send_cw(CW_CLEAN, 4'b1000);
        wait_idle();
        check("corr_cnt_clean", corr_cnt, 0);
        send_cw(CW_DATA, 4'b1000);
        wait_idle();
        check("corr_cnt_data", corr_cnt, CNT_ON ? 1 : 0);
        send_cw(CW_PV, 4'b0110);
        wait_idle();
        send_cw(CW_PH, 4'b0001);
        wait_idle();
        check("corr_cnt_parity", corr_cnt, CNT_ON ? 3 : 0);
        send_cw(CW_DOUBLE, 4'b1010);
        wait_idle();
        check("uncorr_cnt_double", uncorr_cnt, CNT_ON ? 1 : 0);

        // Downstream stall on beat 2.
        send_cw(CW_CLEAN, 4'b0100);
        wait_beat(2);
        bus.T_READY = 1'b0;
        repeat (3) begin
            step();
            check("stall_ready_low", bus.READY, 1'b0);
        end
        bus.T_READY = 1'b1;
        wait_idle();

        // Flush during beat 1 (simultaneous with a beat handshake).
        send_cw(CW_DATA, 4'b0101);
        wait_beat(1);
        bus.IN_TUSER = 1'b1;
        step();
        bus.IN_TUSER = 1'b0;
        check("flush_out_valid", bus.OUT_VALID, 1'b0);
        check("flush_ready", bus.READY, 1'b1);
        check("flush_keeps_corr_cnt", corr_cnt, model_corr);
        wait_idle();
        send_cw(CW_CLEAN, 4'b1000);
        wait_idle();

        // Asynchronous reset during beat 2.
        send_cw(CW_DOUBLE, 4'b1000);
        wait_beat(2);
        ARESET_N = 1'b0;
        #1;
        check("areset_out_valid", bus.OUT_VALID, 1'b0);
        check("areset_ready", bus.READY, 1'b1);
        check("areset_uncorr_cnt", uncorr_cnt, 0);
        @(posedge ACLK);
        #1 ARESET_N = 1'b1;
        send_cw(CW_CLEAN, 4'b1000);
        wait_idle();

        // Randomized traffic with random downstream back-pressure.
        rand_tready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            cw = encode({$urandom, $urandom});
            kind = $urandom_range(0, 4);
            case (kind)
                1: begin idx = $urandom_range(16, 79); cw[idx] = ~cw[idx]; end
                2: begin idx = $urandom_range(8, 15);  cw[idx] = ~cw[idx]; end
                3: begin idx = $urandom_range(0, 7);   cw[idx] = ~cw[idx]; end
                4: begin
                    idx  = $urandom_range(0, 79);
                    idx2 = (idx + $urandom_range(1, 79)) % 80;
                    cw[idx]  = ~cw[idx];
                    cw[idx2] = ~cw[idx2];
                end
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) step();
            send_cw(cw, 4'($urandom_range(0, 15)));
        end
        wait_idle();
        rand_tready = 1'b0;
        bus.T_READY = 1'b1;
        check("final_corr_cnt", corr_cnt, model_corr);
        check("final_uncorr_cnt", uncorr_cnt, model_uncorr);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
